imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory, which the core only reads. It accepts a little-endian byte stream over a valid/ready handshake: a 16-bit instruction count, then the instruction words. It packs each group of four bytes into a 32-bit instruction and writes it at consecutive word addresses. It holds the core in reset until the program is fully written, so the program counter starts at 0 on a loaded image.

## Interface
Parameters:
- DEPTH, 64, instruction memory capacity in 32-bit words.
- BASE_ADDR, 64'd0, byte address of the first written instruction.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte present on in_data.
- in_ready  output  1  loader can accept a byte this cycle.
- in_data  input  8  stream byte.
- reload  input  1  single-cycle request to load a new image (honoured only in DONE).
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  64  byte address of the write (word-aligned).
- wr_data  output  32  instruction word.
- core_reset  output  1  reset to the core; high while loading.
- done  output  1  image fully received.
- overflow  output  1  the count exceeded DEPTH (sticky until the next load).

## Operation
- States: LEN_LO, LEN_HI, DATA, DONE.
- A byte is accepted on an edge where in_valid && in_ready. in_ready = 1 in LEN_LO, LEN_HI and DATA, and 0 in DONE.
- LEN_LO: the accepted byte becomes count[7:0]; go to LEN_HI.
- LEN_HI: the accepted byte becomes count[15:8].
  - If count == 0, go to DONE with no write.
  - Otherwise go to DATA, with word index = 0 and byte lane = 0.
- DATA:
  - Accepted bytes fill lanes 0..3, little-endian: lane 0 goes to bits [7:0], lane 3 to bits [31:24].
  - On the lane-3 byte, issue a write at BASE_ADDR + 4*index, then increment index.
  - When index reaches count, go to DONE.
- Overflow: words with index ≥ DEPTH are consumed but not written (wr_en stays low), and overflow is set to 1. The load still completes at count.
- DONE: done = 1 and core_reset = 0. When reload = 1, go to LEN_LO, set core_reset = 1, clear done and clear overflow.
- reload outside DONE is ignored.
- in_valid low in any loading state holds all state; there is no timeout.
- Arithmetic: index is 16 bits. wr_addr = BASE_ADDR + {index, 2'b00}, zero-extended to 64 bits, with no wrap inside the 16-bit count range.

## Timing
- Reset values: state = LEN_LO, in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0, core_reset = 1, done = 0, overflow = 0.
- Assertion of reset mid-load aborts immediately (asynchronously) to these values. Partially written memory is not cleared.
- Write latency: when the lane-3 byte is accepted at edge k, wr_en/wr_addr/wr_data are registered at k and valid for the single cycle k..k+1. wr_addr and wr_data hold their last values afterwards.
- Throughput: 1 byte/cycle, so 1 write every 4 cycles at full rate.
- When the final byte is accepted at edge k, the state enters DONE and done = 1 at edge k. core_reset falls at edge k+1, so the last write completes before the core leaves reset.
- For count == 0, done rises at the edge accepting the LEN_HI byte, and core_reset falls one edge later.
- reload sampled high in DONE at edge k: core_reset = 1, done = 0 and in_ready = 1 from edge k. A concurrent in_valid byte is not accepted at edge k because in_ready was 0.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (LEN_LO, LEN_HI, DATA, DONE);
  - COUNT_W = 16;
  - LANES = 4.
- Sub-module byte_packer: accepts a byte strobe, tracks the lane counter, assembles the 32-bit word and flags word_complete. The top holds the FSM, index, address generation and the reset/done logic.

## Test plan
- Basic load: stream 02 00, 13 05 10 00, 33 06 a5 00 → two writes: addr 0 data 0x00100513, then addr 4 data 0x00a50633. done = 1; core_reset falls one cycle after the second write.
- Zero count: stream 00 00 → no wr_en, done = 1 after 2 bytes, core_reset low the next cycle.
- Gapped valid: insert random idle cycles between bytes of the basic load → same writes and data, wr_en pulses exactly one cycle each.
- Overflow: DEPTH = 2, count 3, three words → writes at 0 and 4 only, third word consumed, overflow = 1, done = 1.
- Reset mid-load: assert reset after 5 data bytes → all outputs return to reset values. A fresh stream then loads correctly from addr BASE_ADDR.
- Reload: after the basic load, pulse reload together with in_valid → that byte is not accepted, core_reset = 1, overflow cleared. A new count-1 image writes addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      DONE
   } state_t;

   localparam int COUNT_W = 16;
   localparam int LANES   = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words and flags the byte that completes a word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        strobe,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_complete
);

   localparam int LANE_W = $clog2(LANES);

   logic [LANE_W-1:0]          lane;
   logic [8*(LANES-1)-1:0]     low_bytes;

   // Lower lanes shift in from the top, so after three bytes they sit in [23:0].
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane      <= '0;
         low_bytes <= '0;
      end else if (clear) begin
         lane      <= '0;
      end else if (strobe) begin
         lane      <= lane + 1'b1;
         low_bytes <= {data, low_bytes[8*(LANES-1)-1:8]};
      end
   end

   assign word          = {data, low_bytes};
   assign word_complete = strobe && (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a counted byte stream and writes it into instruction memory
// while holding the core in reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [63:0] BASE_ADDR = 64'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        reload,
   output logic        wr_en,
   output logic [63:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_reset,
   output logic        done,
   output logic        overflow
);

   localparam logic [COUNT_W:0] DEPTH_L = (COUNT_W + 1)'(DEPTH);

   state_t               state, state_d;
   logic [COUNT_W-1:0]   count, index, index_next;
   logic                 accept, word_complete, in_range;
   logic [31:0]          word;

   assign in_ready   = (state != DONE);
   assign accept     = in_valid && in_ready;
   assign done       = (state == DONE);
   assign index_next = index + 1'b1;
   assign in_range   = ({1'b0, index} < DEPTH_L);

   byte_packer u_packer (
      .clk           (clk),
      .reset         (reset),
      .clear         (state != DATA),
      .strobe        (accept && (state == DATA)),
      .data          (in_data),
      .word          (word),
      .word_complete (word_complete)
   );

   // NOTE: state_d gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state;
      unique case (state)
         LEN_LO: if (accept) state_d = LEN_HI;
         LEN_HI: if (accept) state_d = ({in_data, count[7:0]} == '0) ? DONE : DATA;
         DATA:   if (word_complete && (index_next == count)) state_d = DONE;
         DONE:   if (reload) state_d = LEN_LO;
         default: state_d = LEN_LO;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LEN_LO;
         count      <= '0;
         index      <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         core_reset <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         state <= state_d;
         wr_en <= word_complete && in_range;
         // Released one edge after DONE is reached, so the final write lands first.
         core_reset <= !((state == DONE) && (state_d == DONE));

         if (accept && (state == LEN_LO)) count[7:0] <= in_data;
         if (accept && (state == LEN_HI)) begin
            count[15:8] <= in_data;
            index       <= '0;
         end

         if (word_complete) begin
            index <= index_next;
            if (in_range) begin
               wr_addr <= BASE_ADDR + {46'd0, index, 2'b00};
               wr_data <= word;
            end else begin
               overflow <= 1'b1;
            end
         end

         if ((state == DONE) && reload) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: two instances (default and a small,
// offset memory) share one stimulus stream and are scored against a stream-level model.
module tb_imem_loader;

   localparam logic [63:0] BASE1  = 64'h100;
   localparam int          DEPTH1 = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        reload = 1'b0;

   logic        in_ready_o   [2];
   logic        wr_en_o      [2];
   logic [63:0] wr_addr_o    [2];
   logic [31:0] wr_data_o    [2];
   logic        core_reset_o [2];
   logic        done_o       [2];
   logic        overflow_o   [2];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  stream [$];
   logic [63:0] got_addr [2][$];
   logic [31:0] got_data [2][$];
   logic [63:0] exp_addr [2][$];
   logic [31:0] exp_data [2][$];
   logic        exp_ovf  [2];

   always #5 clk = ~clk;

   imem_loader dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[0]),
      .in_data(in_data), .reload(reload), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]),
      .wr_data(wr_data_o[0]), .core_reset(core_reset_o[0]), .done(done_o[0]),
      .overflow(overflow_o[0])
   );

   imem_loader #(.DEPTH(DEPTH1), .BASE_ADDR(BASE1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[1]),
      .in_data(in_data), .reload(reload), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]),
      .wr_data(wr_data_o[1]), .core_reset(core_reset_o[1]), .done(done_o[1]),
      .overflow(overflow_o[1])
   );

   // Every cycle with wr_en high records one write; a stretched pulse shows up as an extra entry.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (wr_en_o[d]) begin
            got_addr[d].push_back(wr_addr_o[d]);
            got_data[d].push_back(wr_data_o[d]);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: count header, then count little-endian words at consecutive addresses, capped by depth.
   function automatic void model();
      int cnt;
      int dep;
      logic [63:0] base;
      logic [31:0] w;
      cnt = int'(stream[0]) + (int'(stream[1]) << 8);
      for (int d = 0; d < 2; d++) begin
         dep  = (d == 0) ? 64 : DEPTH1;
         base = (d == 0) ? 64'd0 : BASE1;
         exp_addr[d].delete();
         exp_data[d].delete();
         exp_ovf[d] = (cnt > dep);
         for (int i = 0; i < cnt; i++) begin
            w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
            if (i < dep) begin
               exp_addr[d].push_back(base + 64'(4 * i));
               exp_data[d].push_back(w);
            end
         end
      end
   endfunction

   task automatic build_random(input int cnt);
      stream.delete();
      stream.push_back(8'(cnt));
      stream.push_back(8'(cnt >> 8));
      for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom_range(255, 0)));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      reload = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called right after a negedge; returns at the negedge following the final accepting edge.
   task automatic send_bytes(input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         int g;
         g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
         in_valid = 1'b0;
         repeat (g) @(negedge clk);
         in_valid = 1'b1;
         in_data  = stream[i];
         reload   = (max_gap > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      reload   = 1'b0;
   endtask

   task automatic run_image(input string name, input int max_gap);
      model();
      for (int d = 0; d < 2; d++) begin
         got_addr[d].delete();
         got_data[d].delete();
      end
      send_bytes(stream.size(), max_gap);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (done_o[d] !== 1'b1 || core_reset_o[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s dut%0d after last byte: done=%b core_reset=%b, required done=1 core_reset=1",
                     name, d, done_o[d], core_reset_o[d]);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (core_reset_o[d] !== 1'b0 || done_o[d] !== 1'b1 || in_ready_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dut%0d one cycle later: core_reset=%b done=%b in_ready=%b, required 0 1 0",
                     name, d, core_reset_o[d], done_o[d], in_ready_o[d]);
         end
         n_checks++;
         if (overflow_o[d] !== exp_ovf[d]) begin
            n_fail++;
            $display("FAIL %s dut%0d overflow: got %b, required %b", name, d, overflow_o[d], exp_ovf[d]);
         end
         n_checks++;
         if (got_addr[d].size() != exp_addr[d].size()) begin
            n_fail++;
            $display("FAIL %s dut%0d write count: got %0d, required %0d",
                     name, d, got_addr[d].size(), exp_addr[d].size());
         end else begin
            for (int i = 0; i < exp_addr[d].size(); i++) begin
               n_checks++;
               if (got_addr[d][i] !== exp_addr[d][i] || got_data[d][i] !== exp_data[d][i]) begin
                  n_fail++;
                  $display("FAIL %s dut%0d write %0d: got %h/%h, required %h/%h", name, d, i,
                           got_addr[d][i], got_data[d][i], exp_addr[d][i], exp_data[d][i]);
               end
            end
         end
      end
   endtask

   task automatic check_reset_values(input string name);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if ({in_ready_o[d], wr_en_o[d], core_reset_o[d], done_o[d], overflow_o[d]} !== 5'b10100) begin
            n_fail++;
            $display("FAIL %s dut%0d flags {in_ready,wr_en,core_reset,done,overflow}: got %b, required 10100",
                     name, d, {in_ready_o[d], wr_en_o[d], core_reset_o[d], done_o[d], overflow_o[d]});
         end
         n_checks++;
         if (wr_addr_o[d] !== 64'd0 || wr_data_o[d] !== 32'd0) begin
            n_fail++;
            $display("FAIL %s dut%0d wr_addr/wr_data: got %h/%h, required 0/0",
                     name, d, wr_addr_o[d], wr_data_o[d]);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h06, 8'ha5, 8'h00};
      run_image("basic", 0);
      n_checks++;
      if (got_data[0].size() != 2 || got_addr[0][1] !== 64'd4 || got_data[0][0] !== 32'h00100513
          || got_data[0][1] !== 32'h00a50633) begin
         n_fail++;
         $display("FAIL basic literal words: got %0d writes, required 2 writes 0:00100513 4:00a50633",
                  got_data[0].size());
      end
   endtask

   task automatic test_zero_count();
      do_reset();
      stream = '{8'h00, 8'h00};
      run_image("zero_count", 0);
   endtask

   task automatic test_gapped();
      do_reset();
      stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h06, 8'ha5, 8'h00};
      run_image("gapped", 4);
   endtask

   task automatic test_overflow();
      do_reset();
      build_random(3);
      run_image("overflow", 1);
   endtask

   task automatic test_reset_mid();
      do_reset();
      build_random(4);
      send_bytes(7, 0);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("reset_mid");
      @(negedge clk);
      reset = 1'b0;
      stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h06, 8'ha5, 8'h00};
      run_image("after_reset_mid", 0);
   endtask

   task automatic test_reload();
      do_reset();
      build_random(3);
      run_image("reload_setup", 0);
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h01;
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (core_reset_o[d] !== 1'b1 || done_o[d] !== 1'b0 || in_ready_o[d] !== 1'b1
             || overflow_o[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reload dut%0d: core_reset=%b done=%b in_ready=%b overflow=%b, required 1 0 1 0",
                     d, core_reset_o[d], done_o[d], in_ready_o[d], overflow_o[d]);
         end
      end
      build_random(1);
      run_image("reload_image", 0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         reload = 1'b1;
         @(negedge clk);
         reload = 1'b0;
         build_random($urandom_range(5, 0));
         run_image($sformatf("random%0d", it), $urandom_range(3, 0));
      end
   endtask

   initial begin
      do_reset();
      check_reset_values("power_on");
      test_reset();
      test_basic();
      test_zero_count();
      test_gapped();
      test_overflow();
      test_reset_mid();
      test_reload();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
